// File: rtl/alu_exec_pkg.sv
// Shared opcode encodings and stage states for the handshaked ALU execution stage.
package alu_exec_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_MUL  = 4'd2;
  localparam logic [3:0] OP_DIV  = 4'd3;
  localparam logic [3:0] OP_MOD  = 4'd4;
  localparam logic [3:0] OP_AND  = 4'd5;
  localparam logic [3:0] OP_OR   = 4'd6;
  localparam logic [3:0] OP_XOR  = 4'd7;
  localparam logic [3:0] OP_XNOR = 4'd8;
  localparam logic [3:0] OP_NOT  = 4'd9;
  localparam logic [3:0] OP_SHR  = 4'd10;
  localparam logic [3:0] OP_SHL  = 4'd11;
  localparam logic [3:0] OP_RAND = 4'd12;
  localparam logic [3:0] OP_ROR  = 4'd13;
  localparam logic [3:0] OP_RXOR = 4'd14;
  localparam logic [3:0] OP_EQ   = 4'd15;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_MOD);
  endfunction

endpackage

// File: rtl/alu_serial_div.sv
// Iterative restoring divider: one quotient bit per cycle, WIDTH steps after start.
module alu_serial_div #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] step_quo;
  logic [WIDTH-1:0] step_rem;

  // quo_q doubles as the dividend shift register; its MSB feeds the partial remainder.
  always_comb begin
    rem_sh   = {rem_q, quo_q[WIDTH-1]};
    diff     = rem_sh - {1'b0, div_q};
    step_rem = diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
    step_quo = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
  end

  always_comb begin
    cnt_d = cnt_q;
    quo_d = quo_q;
    rem_d = rem_q;
    div_d = div_q;
    if (start) begin
      cnt_d = CW'(WIDTH);
      quo_d = a;
      rem_d = '0;
      div_d = b;
    end else if (busy) begin
      cnt_d = cnt_q - CW'(1);
      quo_d = step_quo;
      rem_d = step_rem;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      quo_q <= '0;
      rem_q <= '0;
      div_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      quo_q <= quo_d;
      rem_q <= rem_d;
      div_q <= div_d;
    end
  end

  // Final results are presented combinationally during the last step so the
  // stage can capture them on the same edge the divider finishes.
  assign busy = (cnt_q != '0);
  assign done = (cnt_q == CW'(1));
  assign quo  = step_quo;
  assign rem  = step_rem;

endmodule

// File: rtl/alu_exec_stage.sv
// Registered valid/ready execution stage: single-cycle ALU ops plus a serial DIV/MOD path.
module alu_exec_stage
  import alu_exec_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic             out_carry,
  output logic             out_zero,
  output logic             out_dz
);

  state_e           state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;
  logic             dz_q, dz_d;
  logic             is_mod_q, is_mod_d;

  logic             accept;
  logic             div_start;
  logic             div_busy;
  logic             div_done;
  logic [WIDTH-1:0] div_quo;
  logic [WIDTH-1:0] div_rem;

  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     dif;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_carry;
  logic               alu_dz;
  logic [WIDTH-1:0]   div_res;

  assign in_ready  = ((state_q == S_IDLE) | ((state_q == S_DONE) & out_ready)) & ~div_busy;
  assign accept    = in_valid & in_ready;
  assign div_start = accept & is_div_op(in_op) & (in_b != '0);

  alu_serial_div #(.WIDTH(WIDTH)) u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .start (div_start),
    .a     (in_a),
    .b     (in_b),
    .busy  (div_busy),
    .done  (div_done),
    .quo   (div_quo),
    .rem   (div_rem)
  );

  // Only DIV/MOD by zero reach this mux; nonzero divisors take the serial path.
  always_comb begin
    sum       = {1'b0, in_a} + {1'b0, in_b};
    dif       = {1'b0, in_a} - {1'b0, in_b};
    prod      = {{WIDTH{1'b0}}, in_a} * {{WIDTH{1'b0}}, in_b};
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_dz    = 1'b0;
    case (in_op)
      OP_ADD:  begin alu_res = sum[WIDTH-1:0]; alu_carry = sum[WIDTH]; end
      OP_SUB:  begin alu_res = dif[WIDTH-1:0]; alu_carry = dif[WIDTH]; end
      OP_MUL:  begin alu_res = prod[WIDTH-1:0]; alu_carry = |prod[2*WIDTH-1:WIDTH]; end
      OP_DIV:  begin alu_res = '1; alu_dz = 1'b1; end
      OP_MOD:  begin alu_res = in_a; alu_dz = 1'b1; end
      OP_AND:  alu_res = in_a & in_b;
      OP_OR:   alu_res = in_a | in_b;
      OP_XOR:  alu_res = in_a ^ in_b;
      OP_XNOR: alu_res = ~(in_a ^ in_b);
      OP_NOT:  alu_res = ~in_a;
      OP_SHR:  alu_res = in_a >> in_b[SHW-1:0];
      OP_SHL:  alu_res = in_a << in_b[SHW-1:0];
      OP_RAND: alu_res = {{(WIDTH-1){1'b0}}, &in_b};
      OP_ROR:  alu_res = {{(WIDTH-1){1'b0}}, |in_b};
      OP_RXOR: alu_res = {{(WIDTH-1){1'b0}}, ^in_b};
      OP_EQ:   alu_res = {{(WIDTH-1){1'b0}}, in_a == in_b};
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    res_d       = res_q;
    carry_d     = carry_q;
    zero_d      = zero_q;
    dz_d        = dz_q;
    is_mod_d    = is_mod_q;
    div_res     = is_mod_q ? div_rem : div_quo;
    case (state_q)
      S_BUSY: begin
        if (div_done) begin
          res_d       = div_res;
          carry_d     = 1'b0;
          zero_d      = (div_res == '0);
          dz_d        = 1'b0;
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end
      end
      default: begin
        if (div_start) begin
          is_mod_d    = (in_op == OP_MOD);
          out_valid_d = 1'b0;
          state_d     = S_BUSY;
        end else if (accept) begin
          res_d       = alu_res;
          carry_d     = alu_carry;
          zero_d      = (alu_res == '0);
          dz_d        = alu_dz;
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end else if ((state_q == S_DONE) && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      res_q       <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      dz_q        <= 1'b0;
      is_mod_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      res_q       <= res_d;
      carry_q     <= carry_d;
      zero_q      <= zero_d;
      dz_q        <= dz_d;
      is_mod_q    <= is_mod_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_res   = res_q;
  assign out_carry = carry_q;
  assign out_zero  = zero_q;
  assign out_dz    = dz_q;

endmodule
